// File: rtl/frame_chunk_sequencer.sv
// Splits each accepted feature frame into NUM_CHUNKS chunks for a downstream consumer.
// Defining FCS_PREFETCH_EN lets the next frame load during the last chunk handshake.
module frame_chunk_sequencer #(
    parameter int NUM_VALUES        = 40,
    parameter int CHUNK_WIDTH       = 8,
    parameter int FRAMES_PER_WINDOW = 49,
    localparam int NUM_CHUNKS = NUM_VALUES / CHUNK_WIDTH,
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1,
    localparam int CNT_W      = (FRAMES_PER_WINDOW > 1) ? $clog2(FRAMES_PER_WINDOW) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             frame_valid,
    output logic             frame_ready,
    output logic             buf_load,
    output logic             buf_shift,
    output logic             chunk_valid,
    input  logic             chunk_ready,
    output logic [IDX_W-1:0] chunk_idx,
    output logic             chunk_last,
    output logic             window_last,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             window_done
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] chunk_idx_q, chunk_idx_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             window_done_q, window_done_d;
    logic             at_last_chunk;
    logic             at_last_frame;

    assign at_last_chunk = (chunk_idx_q == IDX_W'(NUM_CHUNKS - 1));
    assign at_last_frame = (frame_cnt_q == CNT_W'(FRAMES_PER_WINDOW - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            chunk_idx_q   <= '0;
            frame_cnt_q   <= '0;
            window_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            chunk_idx_q   <= chunk_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            window_done_q <= window_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        chunk_idx_d   = chunk_idx_q;
        frame_cnt_d   = frame_cnt_q;
        window_done_d = 1'b0;
        frame_ready   = 1'b0;
        buf_load      = 1'b0;
        buf_shift     = 1'b0;
        chunk_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    buf_load    = 1'b1;
                    chunk_idx_d = '0;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                chunk_valid = 1'b1;
                if (chunk_ready) begin
                    if (!at_last_chunk) begin
                        chunk_idx_d = chunk_idx_q + IDX_W'(1);
                        buf_shift   = 1'b1;
                    end else begin
                        // Frame complete: count it and return to IDLE unless a frame is prefetched.
                        frame_cnt_d   = at_last_frame ? '0 : frame_cnt_q + CNT_W'(1);
                        window_done_d = at_last_frame;
                        chunk_idx_d   = '0;
                        state_d       = IDLE;
`ifdef FCS_PREFETCH_EN
                        frame_ready = 1'b1;
                        if (frame_valid) begin
                            buf_load = 1'b1;
                            state_d  = STREAM;
                        end
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d       = IDLE;
            chunk_idx_d   = '0;
            frame_cnt_d   = '0;
            window_done_d = 1'b0;
            frame_ready   = 1'b0;
            buf_load      = 1'b0;
            buf_shift     = 1'b0;
        end

        // Keep the buffer strobes quiet while reset is held.
        if (reset) begin
            frame_ready = 1'b0;
            buf_load    = 1'b0;
            buf_shift   = 1'b0;
        end
    end

    assign chunk_idx   = chunk_idx_q;
    assign frame_cnt   = frame_cnt_q;
    assign window_done = window_done_q;
    assign chunk_last  = chunk_valid & at_last_chunk;
    assign window_last = chunk_last & at_last_frame;

endmodule

// File: tb/tb_frame_chunk_sequencer.sv
// Self-checking bench for frame_chunk_sequencer (NUM_VALUES=40, CHUNK_WIDTH=8, FRAMES_PER_WINDOW=3).
module tb_frame_chunk_sequencer;

    localparam int NV     = 40;
    localparam int CW     = 8;
    localparam int FPW    = 3;
    localparam int NC     = NV / CW;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 2;
`ifdef FCS_PREFETCH_EN
    localparam int PERIOD = NC;
`else
    localparam int PERIOD = NC + 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             frame_valid;
    logic             frame_ready;
    logic             buf_load;
    logic             buf_shift;
    logic             chunk_valid;
    logic             chunk_ready;
    logic [IDX_W-1:0] chunk_idx;
    logic             chunk_last;
    logic             window_last;
    logic [CNT_W-1:0] frame_cnt;
    logic             window_done;

    frame_chunk_sequencer #(
        .NUM_VALUES       (NV),
        .CHUNK_WIDTH      (CW),
        .FRAMES_PER_WINDOW(FPW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .buf_load   (buf_load),
        .buf_shift  (buf_shift),
        .chunk_valid(chunk_valid),
        .chunk_ready(chunk_ready),
        .chunk_idx  (chunk_idx),
        .chunk_last (chunk_last),
        .window_last(window_last),
        .frame_cnt  (frame_cnt),
        .window_done(window_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             wlast;
        logic [CNT_W-1:0] fc;
        logic             shift;
    } exp_t;

    exp_t exp_q[$];
    int   push_fc = 0;
    int   total   = 0;
    int   bad     = 0;

    // Scoreboard: each accepted frame queues its expected chunks; each chunk handshake pops one.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (reset || flush) begin
                exp_q.delete();
                push_fc = 0;
            end else begin
                if (chunk_valid && chunk_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL chunk_unexpected: actual idx=%0d required no chunk", chunk_idx);
                    end else begin
                        e       = exp_q.pop_front();
                        a.idx   = chunk_idx;
                        a.last  = chunk_last;
                        a.wlast = window_last;
                        a.fc    = frame_cnt;
                        a.shift = buf_shift;
                        if (a !== e) begin
                            bad++;
                            $display("FAIL chunk_handshake: actual idx=%0d last=%0b wlast=%0b cnt=%0d shift=%0b required idx=%0d last=%0b wlast=%0b cnt=%0d shift=%0b",
                                     a.idx, a.last, a.wlast, a.fc, a.shift, e.idx, e.last, e.wlast, e.fc, e.shift);
                        end
                    end
                end
                if (frame_valid && frame_ready) begin
                    for (int i = 0; i < NC; i++) begin
                        e.idx   = IDX_W'(i);
                        e.last  = (i == NC - 1);
                        e.wlast = (i == NC - 1) && (push_fc == FPW - 1);
                        e.fc    = CNT_W'(push_fc);
                        e.shift = (i != NC - 1);
                        exp_q.push_back(e);
                    end
                    push_fc = (push_fc == FPW - 1) ? 0 : push_fc + 1;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        frame_valid = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        total++;
        if ({chunk_valid, buf_load, buf_shift, window_done, frame_cnt, chunk_idx} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: actual valid=%0b load=%0b shift=%0b done=%0b cnt=%0d idx=%0d required all 0",
                     chunk_valid, buf_load, buf_shift, window_done, frame_cnt, chunk_idx);
        end
        frame_valid = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (frame_ready !== 1'b1 || chunk_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: actual ready=%0b valid=%0b required ready=1 valid=0", frame_ready, chunk_valid);
        end
        tick();
    endtask

    task automatic test_single_frame;
        frame_valid = 1'b1;
        chunk_ready = 1'b1;
        @(negedge clk);
        total++;
        if (buf_load !== 1'b1 || chunk_valid !== 1'b0 || buf_shift !== 1'b0) begin
            bad++;
            $display("FAIL single_t0: actual load=%0b valid=%0b shift=%0b required 1 0 0", buf_load, chunk_valid, buf_shift);
        end
        tick();
        frame_valid = 1'b0;
        for (int k = 0; k < NC; k++) begin
            @(negedge clk);
            total++;
            if (chunk_valid !== 1'b1 || chunk_idx !== IDX_W'(k) || buf_shift !== (k < NC - 1) ||
                chunk_last !== (k == NC - 1) || buf_load !== 1'b0) begin
                bad++;
                $display("FAIL single_chunk%0d: actual valid=%0b idx=%0d shift=%0b last=%0b load=%0b required 1 %0d %0b %0b 0",
                         k, chunk_valid, chunk_idx, buf_shift, chunk_last, buf_load, k, (k < NC - 1), (k == NC - 1));
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (chunk_valid !== 1'b0 || frame_cnt !== CNT_W'(1) || frame_ready !== 1'b1) begin
            bad++;
            $display("FAIL single_done: actual valid=%0b cnt=%0d ready=%0b required 0 1 1", chunk_valid, frame_cnt, frame_ready);
        end
        tick();
    endtask

    task automatic test_flush;
        frame_valid = 1'b1;
        chunk_ready = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (3) tick();
        flush       = 1'b1;
        frame_valid = 1'b1;
        @(negedge clk);
        total++;
        if (chunk_idx !== IDX_W'(3) || frame_ready !== 1'b0 || buf_load !== 1'b0 || buf_shift !== 1'b0) begin
            bad++;
            $display("FAIL flush_cycle: actual idx=%0d ready=%0b load=%0b shift=%0b required 3 0 0 0",
                     chunk_idx, frame_ready, buf_load, buf_shift);
        end
        tick();
        flush       = 1'b0;
        frame_valid = 1'b0;
        @(negedge clk);
        total++;
        if (chunk_valid !== 1'b0 || frame_cnt !== '0 || frame_ready !== 1'b1 || chunk_idx !== '0) begin
            bad++;
            $display("FAIL flush_after: actual valid=%0b cnt=%0d ready=%0b idx=%0d required 0 0 1 0",
                     chunk_valid, frame_cnt, frame_ready, chunk_idx);
        end
        tick();
        frame_valid = 1'b1;
        chunk_ready = 1'b0;
        tick();
        frame_valid = 1'b0;
        @(negedge clk);
        total++;
        if (chunk_valid !== 1'b1 || chunk_idx !== '0) begin
            bad++;
            $display("FAIL flush_restart: actual valid=%0b idx=%0d required 1 0", chunk_valid, chunk_idx);
        end
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        total++;
        if (chunk_valid !== 1'b0 || frame_cnt !== '0) begin
            bad++;
            $display("FAIL flush_abort: actual valid=%0b cnt=%0d required 0 0", chunk_valid, frame_cnt);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int wl = -1;
        int wd = -1;
        int wd_cnt = 0;
        int nacc = 0;
        int bubbles = 0;
        int overlap = 0;
        logic [CNT_W-1:0] fc_wl = '1;
        logic [CNT_W-1:0] fc_wd = '1;
        frame_valid = 1'b1;
        chunk_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (frame_valid && frame_ready) nacc++;
            if (window_last && wl < 0) begin
                wl    = c;
                fc_wl = frame_cnt;
            end
            if (window_done) begin
                wd_cnt++;
                if (wd < 0) begin
                    wd    = c;
                    fc_wd = frame_cnt;
                end
            end
            if (c >= 1 && wl < 0 && !chunk_valid) bubbles++;
            if (buf_load && buf_shift) overlap++;
            tick();
            if (nacc == 3) frame_valid = 1'b0;
        end
        total++;
        if (wl !== 2 * PERIOD + 5 || fc_wl !== CNT_W'(2)) begin
            bad++;
            $display("FAIL b2b_window_last: actual cycle=%0d cnt=%0d required cycle=%0d cnt=2", wl, fc_wl, 2 * PERIOD + 5);
        end
        total++;
        if (wd !== 2 * PERIOD + 6 || fc_wd !== '0 || wd_cnt !== 1) begin
            bad++;
            $display("FAIL b2b_window_done: actual cycle=%0d cnt=%0d pulses=%0d required cycle=%0d cnt=0 pulses=1",
                     wd, fc_wd, wd_cnt, 2 * PERIOD + 6);
        end
        total++;
        if (bubbles !== 2 * (PERIOD - NC)) begin
            bad++;
            $display("FAIL b2b_bubbles: actual %0d required %0d", bubbles, 2 * (PERIOD - NC));
        end
        total++;
        if (overlap !== 0 || nacc !== 3) begin
            bad++;
            $display("FAIL b2b_strobes: actual overlap=%0d frames=%0d required overlap=0 frames=3", overlap, nacc);
        end
    endtask

    task automatic test_stall;
        frame_valid = 1'b1;
        chunk_ready = 1'b1;
        tick();
        frame_valid = 1'b0;
        repeat (2) tick();
        chunk_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            total++;
            if (chunk_valid !== 1'b1 || chunk_idx !== IDX_W'(2) || buf_shift !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d: actual valid=%0b idx=%0d shift=%0b required 1 2 0", s, chunk_valid, chunk_idx, buf_shift);
            end
            tick();
        end
        chunk_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if (chunk_valid !== 1'b0 || frame_cnt !== CNT_W'(1)) begin
            bad++;
            $display("FAIL stall_done: actual valid=%0b cnt=%0d required 0 1", chunk_valid, frame_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_stream;
        frame_valid = 1'b1;
        chunk_ready = 1'b1;
        tick();
        frame_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        total++;
        if (chunk_valid !== 1'b0 || frame_cnt !== '0 || chunk_idx !== '0 || window_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: actual valid=%0b cnt=%0d idx=%0d done=%0b required 0 0 0 0",
                     chunk_valid, frame_cnt, chunk_idx, window_done);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (frame_ready !== 1'b1 || chunk_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_release: actual ready=%0b valid=%0b required 1 0", frame_ready, chunk_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (chunk_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_quiet: actual valid=%0b required 0", chunk_valid);
        end
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        frame_valid = 1'b0;
        chunk_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_flush();
        test_back_to_back();
        test_stall();
        test_reset_mid_stream();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: actual pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_chunk_sequencer.md
FRAME_CHUNK_SEQUENCER -- requirements
Module: frame_chunk_sequencer

Interface
REQ-001 SHALL have parameter NUM_VALUES, default 40, values per feature frame.
REQ-002 SHALL have parameter CHUNK_WIDTH, default 8, values per output chunk; NUM_VALUES mod CHUNK_WIDTH == 0; NUM_CHUNKS = NUM_VALUES/CHUNK_WIDTH.
REQ-003 SHALL have parameter FRAMES_PER_WINDOW, default 49, frames per classification window.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  synchronous window abort.
REQ-007 frame_valid  input  1  upstream has a full frame ready.
REQ-008 frame_ready  output  1  sequencer accepts a frame this cycle.
REQ-009 buf_load  output  1  strobe: chunk buffer captures parallel frame.
REQ-010 buf_shift  output  1  strobe: chunk buffer advances one chunk.
REQ-011 chunk_valid  output  1  current chunk presented downstream.
REQ-012 chunk_ready  input  1  downstream accepts chunk.
REQ-013 chunk_idx  output  $clog2(NUM_CHUNKS) (min 1)  index of presented chunk.
REQ-014 chunk_last  output  1  presented chunk is last of its frame.
REQ-015 window_last  output  1  presented chunk is last chunk of last frame of window.
REQ-016 frame_cnt  output  $clog2(FRAMES_PER_WINDOW) (min 1)  frames completed in current window.
REQ-017 window_done  output  1  one-cycle pulse after window_last chunk handshake.

Function
REQ-018 SHALL implement FSM states IDLE and STREAM.
REQ-019 IDLE: frame_ready=1, chunk_valid=0; on frame_valid&frame_ready SHALL pulse buf_load, set chunk_idx=0, go STREAM next cycle.
REQ-020 STREAM: chunk_valid=1, frame_ready=0 (except REQ-031); chunk_valid SHALL hold with stable chunk_idx until chunk_ready.
REQ-021 Chunk handshake with chunk_idx<NUM_CHUNKS-1 SHALL increment chunk_idx and pulse buf_shift same cycle.
REQ-022 Chunk handshake with chunk_idx==NUM_CHUNKS-1 SHALL go IDLE, pulse no buf_shift, increment frame_cnt.
REQ-023 frame_cnt SHALL wrap FRAMES_PER_WINDOW-1 -> 0 on that completion; window_done SHALL pulse the following cycle.
REQ-024 chunk_last = chunk_valid & (chunk_idx==NUM_CHUNKS-1); window_last = chunk_last & (frame_cnt==FRAMES_PER_WINDOW-1); both combinational.
REQ-025 buf_load and buf_shift SHALL never assert in the same cycle.
REQ-026 First chunk_valid SHALL appear exactly 1 cycle after the frame handshake.
REQ-027 NUM_CHUNKS==1: every handshake in STREAM completes the frame; buf_shift never asserts.
REQ-028 flush=1 SHALL override all else: next state IDLE, chunk_idx=0, frame_cnt=0, window_done=0; frame_ready, buf_load, buf_shift SHALL be 0 during the flush cycle.

Reset
REQ-029 On reset: state IDLE, chunk_idx=0, frame_cnt=0, window_done=0, chunk_valid=0, buf_load=0, buf_shift=0; frame_ready=1 after deassertion.
REQ-030 Reset mid-STREAM SHALL discard the frame with no further chunk_valid until a new frame handshake.

Configuration
REQ-031 Macro FCS_PREFETCH_EN defined: frame_ready also =1 in STREAM when chunk_idx==NUM_CHUNKS-1 and chunk_ready=1; a frame accepted then SHALL pulse buf_load (no buf_shift), set chunk_idx=0, remain STREAM, still count frame completion; steady throughput NUM_CHUNKS cycles/frame.
REQ-032 Macro undefined: frame_ready only in IDLE; minimum NUM_CHUNKS+1 cycles/frame.

Verification (NUM_VALUES=40, CHUNK_WIDTH=8, FRAMES_PER_WINDOW=3)
REQ-033 Reset, then frame_valid=1 one cycle, chunk_ready=1 -> buf_load at T0, chunk_idx 0..4 T1..T5, buf_shift T1..T4, chunk_last T5, frame_cnt=1 at T6.
REQ-034 chunk_ready=0 for 3 cycles at chunk_idx=2 -> chunk_idx stays 2, no buf_shift, chunk_valid held.
REQ-035 Three frames back-to-back -> window_last on third frame's chunk 4, frame_cnt 2->0, window_done pulse 1 cycle later.
REQ-036 flush during chunk_idx=3 of frame 2 -> IDLE next cycle, frame_cnt=0, no buf_shift; next frame starts chunk_idx=0.
REQ-037 FCS_PREFETCH_EN, frame_valid held high, chunk_ready=1 -> 10 chunks in 10 consecutive cycles, buf_load at chunk-4 handshake; without macro -> 1 idle bubble.
REQ-038 reset asserted mid-STREAM at chunk_idx=1 -> chunk_valid=0 immediately, frame_cnt=0, frame_ready=1 after release.
